instr_prefetch_queue: RTL

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue_if.sv | 25 ++
 rtl/instr_prefetch_queue.sv | 72 +++++++
 2 files changed

// File: rtl/instr_prefetch_queue_if.sv
// Handshake bundle between the instruction ROM, the prefetch queue and decode.
// The queue is the slave side; the fetch/decode environment is the master side.
interface instr_prefetch_queue_if #(
    parameter int IW = 16,
    parameter int CW = 3
);
    logic [IW-1:0] in_instr;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] out_instr;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output in_instr, in_valid, out_ready, flush,
        input  in_ready, out_instr, out_valid, count
    );

    modport slave (
        input  in_instr, in_valid, out_ready, flush,
        output in_ready, out_instr, out_valid, count
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Small FIFO between instruction ROM and decode; flush discards contents on redirect.
// Registered storage only, so a pushed word is visible to decode one cycle later.
module instr_prefetch_queue #(
    parameter int IW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic                   clk,
    input logic                   rstn,
    instr_prefetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Acceptance depends on stored state only: no slot is freed by a same-cycle pop.
    assign push  = bus.in_valid && !full && !bus.flush;
    assign pop   = !empty && bus.out_ready && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.in_instr;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.count     = count_q;

    count_bound_a: assert property (@(posedge clk) disable iff (!rstn) count_q <= CW'(DEPTH));
endmodule
